// File: rtl/ex.sv
// Execute stage: logic/shift ALU, pass-through of the write-back request and an
// optional 32-cycle radix-2 divider for DIV/DIVU (enabled by defining EX_DIV_EN).
// Ports: clk/rst (sync, active-high), aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i
// from ID/EX; wd_o/wreg_o/wdata_o to EX/MEM; whilo_o/hi_o/lo_o HI/LO write;
// stallreq_o pipeline hold while a divide is in flight.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [4:0]  sa;

    assign sa = reg1_i[4:0];

    always_comb begin
        logic_res = '0;
        unique case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        unique case (aluop_i)
            OP_SLL:  shift_res = reg2_i << sa;
            OP_SRL:  shift_res = reg2_i >> sa;
            OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> sa);
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        wd_o    = '0;
        wreg_o  = 1'b0;
        wdata_o = '0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            unique case (alusel_i)
                SEL_LOGIC: wdata_o = logic_res;
                SEL_SHIFT: wdata_o = shift_res;
                default:   wdata_o = '0;
            endcase
        end
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  cnt;
    // quo holds the dividend while shifting and collects quotient bits
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic        is_div;
    logic        is_sdiv;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [31:0] q_step;
    logic [31:0] r_step;

    assign is_sdiv = (aluop_i == OP_DIV);
    assign is_div  = is_sdiv || (aluop_i == OP_DIVU);

    // one restoring step: bit 32 of diff is the borrow
    always_comb begin
        rem_sh = {rem, quo[31]};
        diff   = rem_sh - {1'b0, dvs};
        if (!diff[32]) begin
            r_step = diff[31:0];
            q_step = {quo[30:0], 1'b1};
        end else begin
            r_step = rem_sh[31:0];
            q_step = {quo[30:0], 1'b0};
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (is_div)
                    state_nx = (reg2_i == '0) ? S_DIVZERO : S_ON;
            end
            S_ON: begin
                if (cnt == 6'd31)
                    state_nx = S_END;
            end
            S_DIVZERO: state_nx = S_END;
            S_END:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_div && reg2_i != '0) begin
                        cnt <= '0;
                        rem <= '0;
                        if (is_sdiv) begin
                            quo   <= reg1_i[31] ? -reg1_i : reg1_i;
                            dvs   <= reg2_i[31] ? -reg2_i : reg2_i;
                            neg_q <= reg1_i[31] ^ reg2_i[31];
                            neg_r <= reg1_i[31];
                        end else begin
                            quo   <= reg1_i;
                            dvs   <= reg2_i;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end
                    end
                end
                S_ON: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        quo <= neg_q ? -q_step : q_step;
                        rem <= neg_r ? -r_step : r_step;
                    end else begin
                        quo <= q_step;
                        rem <= r_step;
                    end
                end
                S_DIVZERO: begin
                    quo <= '0;
                    rem <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        if (!rst) begin
            unique case (state)
                S_IDLE:    stallreq_o = is_div;
                S_ON:      stallreq_o = 1'b1;
                S_DIVZERO: stallreq_o = 1'b1;
                S_END: begin
                    whilo_o = 1'b1;
                    hi_o    = rem;
                    lo_o    = quo;
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    assign stallreq_o = 1'b0;
    assign whilo_o    = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
`endif

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: random logic/shift ops and divides against a
// behavioural model, plus the directed cases and mid-divide reset.
module tb_ex;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_wdata(input logic [7:0] op,
                                             input logic [2:0] sel,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        sh = a % 32;
        if (sel == 3'd1) begin
            if (op == 8'h24) return a & b;
            if (op == 8'h25) return a | b;
            if (op == 8'h26) return a ^ b;
            if (op == 8'h27) return ~(a | b);
            return 32'h0;
        end
        if (sel == 3'd2) begin
            if (op == 8'h7C) return b * (32'd1 << sh);
            if (op == 8'h02) return b / (32'd1 << sh);
            if (op == 8'h03)
                return (b / (32'd1 << sh)) | (b[31] ? ~(ones >> sh) : 32'h0);
            return 32'h0;
        end
        return 32'h0;
    endfunction

    task automatic ref_div(input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] q,
                           output logic [31:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = 0;
            r = 0;
        end else if (op == 8'h1B) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic run_comb(input string tag, input logic [7:0] op,
                            input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] d,
                            input logic we);
        @(posedge clk);
        #1;
        aluop  = op;
        alusel = sel;
        reg1   = a;
        reg2   = b;
        wd     = d;
        wreg   = we;
        @(negedge clk);
        check({tag, "_wdata"}, wdata_o, ref_wdata(op, sel, a, b));
        check({tag, "_wd"}, {27'd0, wd_o}, {27'd0, d});
        check({tag, "_wreg"}, {31'd0, wreg_o}, {31'd0, we});
        check({tag, "_idle"}, {30'd0, stallreq_o, whilo_o}, 32'd0);
    endtask

    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        int ns;
        bit got;
        ref_div(op, a, b, eq, er);
        @(posedge clk);
        #1;
        aluop  = op;
        alusel = 3'd0;
        reg1   = a;
        reg2   = b;
        wd     = 5'($urandom);
        wreg   = 1'b0;
`ifdef EX_DIV_EN
        ns  = 0;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (whilo_o) begin
                got = 1;
                break;
            end
            if (stallreq_o) ns++;
        end
        check({tag, "_done"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_stalls"}, ns, (b == 0) ? 2 : 33);
            check({tag, "_lo"}, lo_o, eq);
            check({tag, "_hi"}, hi_o, er);
            check({tag, "_endst"}, {30'd0, stallreq_o, wreg_o}, 32'd0);
            check({tag, "_wdata"}, wdata_o, 32'd0);
        end
        @(posedge clk);
        #1;
        aluop = 8'h00;
        @(negedge clk);
        check({tag, "_after"}, {30'd0, stallreq_o, whilo_o}, 32'd0);
`else
        ns  = 0;
        got = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stallreq_o || whilo_o) ns++;
            if (hi_o != 0 || lo_o != 0 || wdata_o != 0) got = 1;
        end
        check({tag, "_nodiv_ctl"}, ns, 0);
        check({tag, "_nodiv_data"}, {31'd0, got}, 32'd0);
        @(posedge clk);
        #1;
        aluop = 8'h00;
`endif
    endtask

    logic [7:0] ops [0:8] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C,
                              8'h02, 8'h03, 8'h55, 8'h00};

    initial begin
        rst    = 1'b1;
        aluop  = 8'h25;
        alusel = 3'd1;
        reg1   = 32'hFFFF_FFFF;
        reg2   = 32'h1234_5678;
        wd     = 5'd9;
        wreg   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wd", {27'd0, wd_o}, 32'd0);
        check("rst_ctl", {29'd0, wreg_o, stallreq_o, whilo_o}, 32'd0);
        check("rst_hilo", hi_o | lo_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_comb("or_dir", 8'h25, 3'd1, 32'h0000_FF00, 32'h00FF_0000, 5'd5, 1'b1);
        run_comb("sra_dir", 8'h03, 3'd2, 32'd4, 32'h8000_0010, 5'd3, 1'b1);
        check("sra_val", wdata_o, 32'hF800_0001);
        run_comb("srl_dir", 8'h02, 3'd2, 32'd4, 32'h8000_0010, 5'd3, 1'b1);
        check("srl_val", wdata_o, 32'h0800_0001);
        run_comb("sll_31", 8'h7C, 3'd2, 32'd31, 32'h0000_0003, 5'd1, 1'b0);
        run_comb("bad_sel", 8'h25, 3'd5, 32'hFFFF_0000, 32'h0000_FFFF, 5'd2, 1'b1);

        for (int i = 0; i < 200; i++) begin
            run_comb("rnd", ops[$urandom_range(0, 8)], 3'($urandom_range(0, 3)),
                     $urandom, $urandom, 5'($urandom), 1'($urandom));
        end

        run_div("divu_dir", 8'h1B, 32'd100, 32'd7);
        run_div("div_neg", 8'h1A, 32'hFFFF_FF9C, 32'd7);
        run_div("div_ovf", 8'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("div_zero", 8'h1A, 32'h1234_5678, 32'd0);
        run_div("divu_zero", 8'h1B, 32'hFFFF_FFFF, 32'd0);
        run_div("divu_big", 8'h1B, 32'hFFFF_FFFF, 32'h8000_0000);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] b;
            b = (i % 5 == 4) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_div("div_rnd", (i % 2 == 1) ? 8'h1A : 8'h1B, $urandom, b);
        end

        @(posedge clk);
        #1;
        aluop  = 8'h1B;
        alusel = 3'd0;
        reg1   = 32'd100;
        reg2   = 32'd7;
        wd     = 5'd4;
        wreg   = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctl", {29'd0, wreg_o, stallreq_o, whilo_o}, 32'd0);
        check("midrst_hilo", hi_o | lo_o, 32'd0);
        check("midrst_wd", {27'd0, wd_o}, 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        aluop = 8'h00;
        @(negedge clk);
        check("postrst", {30'd0, stallreq_o, whilo_o}, 32'd0);
        run_div("divu_fresh", 8'h1B, 32'd100, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
